// File: rtl/phase_sequencer.sv
// CPU phase sequencer: one-hot fetch/execute phase generator with run/stop/single
// control, a sticky overrun trap and a completed-instruction counter.
module phase_sequencer #(
  parameter int MAXPHASE = 6,
  parameter int ICW      = 12
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           stop,
  input  logic           single,
  input  logic           done,
  output logic           fetch_ck,
  output logic           fetch_stb,
  output logic           ck1,
  output logic           ck2,
  output logic           ck3,
  output logic           ck4,
  output logic           ck5,
  output logic           ck6,
  output logic           stb1,
  output logic           stb2,
  output logic           stb3,
  output logic           stb4,
  output logic           stb5,
  output logic           stb6,
  output logic           running,
  output logic           overrun,
  output logic [ICW-1:0] icount
);

  // State k: 0 = HALT, 1 = F_CK, 2 = F_STB, 2N+1 = EN_CK, 2N+2 = EN_STB.
  localparam logic [3:0] S_HALT     = 4'd0;
  localparam logic [3:0] S_F_CK     = 4'd1;
  localparam logic [3:0] S_F_STB    = 4'd2;
  localparam logic [3:0] S_LAST_STB = 4'(2 * MAXPHASE + 2);

  logic [3:0]     r_state;
  logic [3:0]     w_next;
  logic [14:1]    r_phase;
  logic [14:1]    w_phase;
  logic           r_running;
  logic           w_running;
  logic           r_overrun;
  logic [ICW-1:0] r_icount;
  logic           w_is_ck;
  logic           w_is_stb;
  logic           w_accept;
  logic           w_overrun_set;

  // State register plus the phase/running flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_HALT;
      r_phase   <= '0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_phase   <= w_phase;
      r_running <= w_running;
    end
  end

  // Classify the current state and decide the next one.
  always_comb begin
    w_is_ck       = (r_state >= 4'd3) && r_state[0] && (r_state < S_LAST_STB);
    w_is_stb      = (r_state >= 4'd4) && !r_state[0];
    w_accept      = w_is_ck && done;
    w_overrun_set = (r_state == S_LAST_STB);
    w_next        = S_HALT;
    if (r_state == S_HALT) begin
      if (start && !stop) begin
        w_next = S_F_CK;
      end else begin
        w_next = S_HALT;
      end
    end else if ((r_state == S_F_CK) || (r_state == S_F_STB)) begin
      w_next = r_state + 4'd1;
    end else if (w_accept) begin
      if (stop || single) begin
        w_next = S_HALT;
      end else begin
        w_next = S_F_CK;
      end
    end else if (w_is_ck) begin
      w_next = r_state + 4'd1;
    end else if (w_is_stb && (r_state < S_LAST_STB)) begin
      w_next = r_state + 4'd1;
    end else begin
      w_next = S_HALT;
    end
  end

  // Decode the next state into one-hot phase enables so outputs land with the state.
  always_comb begin
    w_phase = '0;
    for (int k = 1; k <= 14; k++) begin
      w_phase[k] = (w_next == 4'(k));
    end
    w_running = (w_next != S_HALT);
  end

  // Instruction counter and sticky overrun trap (cleared by the next start).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_icount  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_icount <= r_icount + ICW'(1);
      end else begin
        r_icount <= r_icount;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if ((r_state == S_HALT) && (w_next == S_F_CK)) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign fetch_ck  = r_phase[1];
  assign fetch_stb = r_phase[2];
  assign ck1       = r_phase[3];
  assign stb1      = r_phase[4];
  assign ck2       = r_phase[5];
  assign stb2      = r_phase[6];
  assign ck3       = r_phase[7];
  assign stb3      = r_phase[8];
  assign ck4       = r_phase[9];
  assign stb4      = r_phase[10];
  assign ck5       = r_phase[11];
  assign stb5      = r_phase[12];
  assign ck6       = r_phase[13];
  assign stb6      = r_phase[14];
  assign running   = r_running;
  assign overrun   = r_overrun;
  assign icount    = r_icount;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: per-cycle compare against an
// instruction-offset model plus directed literal checks.
module tb_phase_sequencer;

  localparam int MAXP = 6;
  localparam int ICW  = 12;

  logic clk = 1'b0;
  logic reset_n, start, stop, single, done;
  logic fetch_ck, fetch_stb;
  logic ck1, ck2, ck3, ck4, ck5, ck6;
  logic stb1, stb2, stb3, stb4, stb5, stb6;
  logic running, overrun;
  logic [ICW-1:0] icount;

  logic [6:1]  done_mask;
  logic [6:1]  ck_vec;
  logic [13:0] dut_vec;
  logic        cmp_en;

  int checks   = 0;
  int failures = 0;

  // Model: offset within the current instruction (0 = fetch_ck, 1 = fetch_stb, 2N = ckN, 2N+1 = stbN).
  logic           m_run;
  int             m_cyc;
  logic           m_ovr;
  logic [ICW-1:0] m_cnt;
  logic [13:0]    exp_vec;

  phase_sequencer #(.MAXPHASE(MAXP), .ICW(ICW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .single(single), .done(done),
    .fetch_ck(fetch_ck), .fetch_stb(fetch_stb),
    .ck1(ck1), .ck2(ck2), .ck3(ck3), .ck4(ck4), .ck5(ck5), .ck6(ck6),
    .stb1(stb1), .stb2(stb2), .stb3(stb3), .stb4(stb4), .stb5(stb5), .stb6(stb6),
    .running(running), .overrun(overrun), .icount(icount)
  );

  always #5 clk = ~clk;

  assign ck_vec  = {ck6, ck5, ck4, ck3, ck2, ck1};
  assign done    = |(done_mask & ck_vec);
  assign dut_vec = {stb6, ck6, stb5, ck5, stb4, ck4, stb3, ck3, stb2, ck2, stb1, ck1, fetch_stb, fetch_ck};
  assign exp_vec = m_run ? (14'(1) << m_cyc) : 14'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_halt(input string name, input int bound);
    int n = 0;
    while (running && n < bound) begin
      tick(1);
      n++;
    end
    check(name, 32'(running), 32'd0);
  endtask

  task automatic pulse_reset(input string name);
    reset_n = 1'b0;
    tick(1);
    check(name, 32'({dut_vec, running, overrun, icount}), 32'd0);
    reset_n = 1'b1;
  endtask

  // Model update from the rules: accept on done in a ck offset, trap after stbMAXP.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_run <= 1'b0;
      m_cyc <= 0;
      m_ovr <= 1'b0;
      m_cnt <= '0;
    end else if (!m_run) begin
      if (start && !stop) begin
        m_run <= 1'b1;
        m_cyc <= 0;
        m_ovr <= 1'b0;
      end
    end else if (m_cyc >= 2 && (m_cyc % 2) == 0 && done) begin
      m_cnt <= m_cnt + ICW'(1);
      m_cyc <= 0;
      if (stop || single) m_run <= 1'b0;
    end else if (m_cyc == 2 * MAXP + 1) begin
      m_run <= 1'b0;
      m_ovr <= 1'b1;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("phases", 32'(dut_vec), 32'(exp_vec));
      check("onehot", 32'($countones(dut_vec) <= 1), 32'd1);
      check("running", 32'(running), 32'(m_run));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("icount", 32'(icount), 32'(m_cnt));
    end
  end

  initial begin
    int seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0};
    int n;
    cmp_en    = 1'b0;
    reset_n   = 1'b0;
    start     = 1'b1;
    stop      = 1'b0;
    single    = 1'b0;
    done_mask = 6'b000001;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;
    tick(2);
    check("reset_outputs", 32'({dut_vec, running, overrun, icount}), 32'd0);

    // NOP stream: fetch_ck, fetch_stb, ck1 every 3 cycles
    reset_n = 1'b1;
    tick(12);
    check("nop_icount", 32'(icount), 32'd3);
    check("nop_ck1", 32'(ck1), 32'd1);
    start = 1'b0;
    stop  = 1'b1;
    tick(1);
    check("nop_stop_halt", 32'(running), 32'd0);
    check("nop_stop_icount", 32'(icount), 32'd4);
    start = 1'b1;
    tick(2);
    check("start_stop_halt", 32'(running), 32'd0);

    // Swap-length instruction: done only at ck4
    stop      = 1'b0;
    done_mask = 6'b001000;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("swap_seq", 32'(dut_vec), 32'(14'(1) << seq[i]));
      tick(1);
    end
    stop = 1'b1;
    wait_halt("swap_halt", 40);
    stop = 1'b0;

    // Single mode with done at ck2
    pulse_reset("reset_single");
    single    = 1'b1;
    done_mask = 6'b000010;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    wait_halt("single_halt1", 20);
    check("single_icount1", 32'(icount), 32'd1);
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_halt("single_halt2", 20);
    check("single_icount2", 32'(icount), 32'd2);
    single = 1'b0;

    // Stop raised at stb1, done at ck3
    pulse_reset("reset_stop");
    done_mask = 6'b000100;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!stb1 && n < 20) begin
      tick(1);
      n++;
    end
    check("reach_stb1", 32'(stb1), 32'd1);
    stop = 1'b1;
    wait_halt("stop_halt", 20);
    check("stop_icount", 32'(icount), 32'd1);
    tick(5);
    check("stop_no_fetch", 32'(fetch_ck), 32'd0);
    stop = 1'b0;

    // Overrun: no done at all
    done_mask = 6'b000000;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    wait_halt("ovr_halt", 40);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_icount", 32'(icount), 32'd1);
    start = 1'b1;
    tick(1);
    check("ovr_restart_fetch", 32'(fetch_ck), 32'd1);
    check("ovr_restart_clear", 32'(overrun), 32'd0);
    start     = 1'b0;
    stop      = 1'b1;
    done_mask = 6'b000001;
    wait_halt("ovr_done_halt", 10);
    stop = 1'b0;

    // Wrap: 4096 NOPs bring icount back to 0
    pulse_reset("reset_wrap");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (icount != 12'd4095 && n < 14000) begin
      tick(1);
      n++;
    end
    check("reach_4095", 32'(icount), 32'd4095);
    stop = 1'b1;
    wait_halt("wrap_halt", 10);
    check("wrap_icount", 32'(icount), 32'd0);
    stop = 1'b0;

    // Reset during ck2 forces reset values on the next edge
    done_mask = 6'b000010;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!ck2 && n < 20) begin
      tick(1);
      n++;
    end
    check("reach_ck2", 32'(ck2), 32'd1);
    pulse_reset("reset_mid_ck2");
    tick(2);
    check("post_reset_idle", 32'(running), 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
